// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low matrix keypad, debounces one key and reports its code.
// Latency : press-to-pulse <= 4*SCAN_DIV + DEBOUNCE_CYCLES + 3 clocks from a stable low on row_n.
// Backpress: none; rec_num/rec_op are single-cycle strobes and clickedMatrix holds the last code.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   row_n[3:0]    row sense lines (active-low, pulled up, asynchronous to clk)
//   col_n[3:0]    column drive, one-cold
//   clickedMatrix code of the last accepted key, held until the next one
//   rec_num       one-cycle strobe: accepted key is a digit (0-9)
//   rec_op        one-cycle strobe: accepted key is an operator/control (A-F)
//
// Code map (row r, column c left to right):
//   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: E 0 F D
//   A add, B subtract, C multiply, D divide, E clear, F equals.
//
// SCAN_DIV must be >= 4 so that the two-flop synchronizer has settled on the
// currently driven column before the end-of-slot sample. DEBOUNCE_CYCLES must
// be >= 2.

module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] clickedMatrix,
  output logic       rec_num,
  output logic       rec_op
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchronizer. Reset to all-ones so an idle keypad reads as released.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] rs_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      rs_n    <= 4'hF;
    end else begin
      sync1_q <= row_n;
      rs_n    <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Key position to code.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [1:0]        key_row_q, key_row_d;
  logic [3:0]        code_q, code_d;
  logic              rec_num_q, rec_num_d;
  logic              rec_op_q, rec_op_d;

  // Lowest-index low row wins when several keys in one column are down.
  logic       any_low;
  logic [1:0] low_row;

  always_comb begin
    any_low = ~&rs_n;
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_n[i]) low_row = 2'(i);
    end
  end

  logic [3:0] cur_code;
  assign cur_code = key_code(key_row_q, col_q);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    slot_d    = slot_q;
    deb_d     = deb_q;
    key_row_d = key_row_q;
    code_d    = code_q;
    rec_num_d = 1'b0;
    rec_op_d  = 1'b0;

    case (state_q)
      SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (any_low) begin
            // Column stays driven (frozen) while the key is qualified.
            key_row_d = low_row;
            deb_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (!rs_n[key_row_q]) begin
          if (deb_q == DEB_LAST) begin
            // Code and strobe register on the same edge, so clickedMatrix is
            // already valid during the cycle the strobe is high.
            deb_d     = '0;
            state_d   = EMIT;
            code_d    = cur_code;
            rec_num_d = (cur_code <= 4'd9);
            rec_op_d  = (cur_code >  4'd9);
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          // Bounce: drop the candidate and carry on from the next column.
          deb_d   = '0;
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          slot_d  = '0;
        end
      end

      EMIT: begin
        deb_d   = '0;
        state_d = WAIT_REL;
      end

      WAIT_REL: begin
        if (&rs_n) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            slot_d  = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      slot_q    <= '0;
      deb_q     <= '0;
      key_row_q <= 2'd0;
      code_q    <= 4'h0;
      rec_num_q <= 1'b0;
      rec_op_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      slot_q    <= slot_d;
      deb_q     <= deb_d;
      key_row_q <= key_row_d;
      code_q    <= code_d;
      rec_num_q <= rec_num_d;
      rec_op_q  <= rec_op_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign col_n         = ~(4'b0001 << col_q);
  assign clickedMatrix = code_q;
  assign rec_num       = rec_num_q;
  assign rec_op        = rec_op_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks each column is driven per scan slot; minimum 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable cycles required to accept a press or release; minimum 2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 row_n  input  4  keypad row sense lines, active-low, pulled up externally, asynchronous to clk.
REQ-006 col_n  output  4  keypad column drive, one-cold (exactly one bit low at all times).
REQ-007 clickedMatrix  output  4  code of last accepted key; held until the next accepted key.
REQ-008 rec_num  output  1  one-cycle pulse: accepted key is a digit (code 0-9).
REQ-009 rec_op  output  1  one-cycle pulse: accepted key is an operator/control (code A-F).

Function
REQ-010 row_n SHALL pass through a 2-flop synchronizer; only synchronized rows (rs_n) are used.
REQ-011 Key position (r,c) SHALL map to codes: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D (c = 0..3 left to right).
REQ-012 Code meanings for the downstream calculator: A add, B subtract, C multiply, D divide, E clear, F equals.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, EMIT and WAIT_REL.
REQ-014 In SCAN, col_n SHALL drive column k low for SCAN_DIV cycles, then advance to k+1, wrapping 3 -> 0.
REQ-015 Rows SHALL be sampled only in the last cycle of each column slot.
REQ-016 In SCAN, a sample with any rs_n bit low SHALL latch the column and the lowest-index low row, freeze col_n, and go to DEBOUNCE.
REQ-017 In DEBOUNCE, the counter SHALL increment each cycle the latched row is low; reaching DEBOUNCE_CYCLES goes to EMIT.
REQ-018 In DEBOUNCE, the latched row going high SHALL clear the counter and return to SCAN, resuming at the next column with no output.
REQ-019 EMIT SHALL last exactly one cycle: it updates clickedMatrix and pulses rec_num (code <= 9) or rec_op (code >= A), never both, then goes to WAIT_REL.
REQ-020 In WAIT_REL, col_n SHALL stay frozen and no further pulses SHALL occur however long the key is held.
REQ-021 In WAIT_REL, DEBOUNCE_CYCLES consecutive cycles with all rs_n high SHALL return the FSM to SCAN.
REQ-022 Any low row seen in WAIT_REL SHALL restart the release count.
REQ-023 Outside EMIT, rec_num and rec_op SHALL be 0.
REQ-024 Press-to-pulse latency SHALL be at most 4*SCAN_DIV + DEBOUNCE_CYCLES + 3 cycles from a stable low on row_n.
REQ-025 Simultaneous keys in one column SHALL resolve to the lowest row.
REQ-026 Keys in other columns SHALL be ignored until WAIT_REL exits.

Reset
REQ-027 While rst_n = 0 (asynchronously), the block SHALL hold: state SCAN, column 0 (col_n = 4'b1110), slot and debounce counters 0, clickedMatrix 4'h0, rec_num = rec_op = 0, synchronizer flops all 1.
REQ-028 Reset mid-DEBOUNCE or mid-WAIT_REL SHALL discard the pending key with no pulse; scanning SHALL restart at column 0 on the first clock after release.

Verification (SCAN_DIV = 4, DEBOUNCE_CYCLES = 8)
REQ-029 Assert rst_n = 0, then release -> col_n = 1110, clickedMatrix = 0, no pulses; col_n = 1101 after 4 clocks.
REQ-030 Hold key at row1/col2 for 60 cycles, then release -> exactly one rec_num pulse with clickedMatrix = 4'h6, rec_op never high.
REQ-031 Drive row0 low for 3 cycles during col0 (bounce), then high -> no pulse; scanning continues 1110 -> 1101.
REQ-032 Hold row3/col3 for 300 cycles, release for 20, press again -> two rec_op pulses, clickedMatrix = 4'hD each time.
REQ-033 Press rows 0 and 2 together in col1 -> one rec_num pulse, clickedMatrix = 4'h2.
REQ-034 Pulse rst_n low 4 cycles into DEBOUNCE of key row2/col0 -> no pulse, clickedMatrix stays 0, col_n = 1110.
